uart_rx_controller: RTL and testbench



---
 rtl/uart_rx_controller.sv | 154 +++++++++++++++
 tb/tb_uart_rx_controller.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_controller.sv
// uart_rx_controller: 8N1 UART receiver. Two-flop synchroniser, mid-bit sampling,
// registered byte/done/active/frame-error outputs.
module uart_rx_controller #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_Rx_Serial,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Done,
  output logic       o_Rx_Active,
  output logic       o_Rx_Frame_Err
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'((CLKS_PER_BIT - 1) / 2);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitHigh
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      sync_q, sync_d;
  logic [CntW-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      byte_q, byte_d;
  logic            done_q, done_d;
  logic            active_q, active_d;
  logic            err_q, err_d;
  logic            rx_s;

  assign rx_s = sync_q[1];

  // Next-state logic: synchroniser shift, frame FSM, one-cycle pulse outputs.
  always_comb begin
    sync_d    = {sync_q[0], i_Rx_Serial};
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    byte_d    = byte_q;
    done_d    = 1'b0;
    active_d  = active_q;
    err_d     = 1'b0;

    case (state_q)
      StIdle: begin
        clk_cnt_d = '0;
        bit_idx_d = '0;
        if (!rx_s) begin
          state_d  = StStart;
          active_d = 1'b1;
        end
      end

      StStart: begin
        if (clk_cnt_q < CntHalf) begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end else if (!rx_s) begin
          clk_cnt_d = '0;
          state_d   = StData;
        end else begin
          // Line back high at mid-start: a glitch, drop it silently.
          clk_cnt_d = '0;
          state_d   = StIdle;
          active_d  = 1'b0;
        end
      end

      StData: begin
        if (clk_cnt_q == CntLast) begin
          clk_cnt_d = '0;
          shift_d   = {rx_s, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = '0;
            state_d   = StStop;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      StStop: begin
        if (clk_cnt_q == CntLast) begin
          clk_cnt_d = '0;
          active_d  = 1'b0;
          if (rx_s) begin
            byte_d  = shift_q;
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            err_d   = 1'b1;
            state_d = StWaitHigh;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      // A held-low line (break) must return high before a new start is accepted.
      StWaitHigh: begin
        if (rx_s) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d   = StIdle;
        clk_cnt_d = '0;
        bit_idx_d = '0;
        active_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset discards any partial frame immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      sync_q    <= 2'b11;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      byte_q    <= '0;
      done_q    <= 1'b0;
      active_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      byte_q    <= byte_d;
      done_q    <= done_d;
      active_q  <= active_d;
      err_q     <= err_d;
    end
  end

  assign o_Rx_Byte      = byte_q;
  assign o_Rx_Done      = done_q;
  assign o_Rx_Active    = active_q;
  assign o_Rx_Frame_Err = err_q;

endmodule

// File: tb/tb_uart_rx_controller.sv
// Directed bench for uart_rx_controller at CLKS_PER_BIT=16 and CLKS_PER_BIT=4.
module tb_uart_rx_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       line = 1'b1;
  logic       sel = 1'b0;   // 0: 16-clock instance, 1: 4-clock instance
  int         cpb = 16;
  int         cyc = 0;

  logic       rx16, rx4;
  logic [7:0] byte16, byte4;
  logic       done16, done4, act16, act4, err16, err4;

  logic [7:0] mon_byte;
  logic       mon_done, mon_act, mon_err;

  int         n_cmp = 0;
  int         n_mis = 0;

  int         done_cyc_q[$];
  int         done_byte_q[$];
  int         err_cnt = 0;
  int         overlap = 0;
  int         act_rise = 0;
  int         act_lo = 0;
  logic       act_prev = 1'b0;

  assign rx16     = sel ? 1'b1 : line;
  assign rx4      = sel ? line : 1'b1;
  assign mon_byte = sel ? byte4 : byte16;
  assign mon_done = sel ? done4 : done16;
  assign mon_act  = sel ? act4 : act16;
  assign mon_err  = sel ? err4 : err16;

  uart_rx_controller #(.CLKS_PER_BIT(16)) u_dut16 (
    .clk            (clk),
    .reset          (reset),
    .i_Rx_Serial    (rx16),
    .o_Rx_Byte      (byte16),
    .o_Rx_Done      (done16),
    .o_Rx_Active    (act16),
    .o_Rx_Frame_Err (err16)
  );

  uart_rx_controller #(.CLKS_PER_BIT(4)) u_dut4 (
    .clk            (clk),
    .reset          (reset),
    .i_Rx_Serial    (rx4),
    .o_Rx_Byte      (byte4),
    .o_Rx_Done      (done4),
    .o_Rx_Active    (act4),
    .o_Rx_Frame_Err (err4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe outputs on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (mon_done) begin
      done_cyc_q.push_back(cyc);
      done_byte_q.push_back(int'(mon_byte));
    end
    if (mon_err) err_cnt++;
    if (mon_done && mon_err) overlap++;
    if (mon_act && !act_prev) act_rise++;
    act_prev = mon_act;
  end

  task automatic check_val(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic int q_at(input int idx);
    if (idx < done_cyc_q.size()) return done_cyc_q[idx];
    return -1;
  endfunction

  function automatic int b_at(input int idx);
    if (idx < done_byte_q.size()) return done_byte_q[idx];
    return -1;
  endfunction

  task automatic clear_mon();
    done_cyc_q.delete();
    done_byte_q.delete();
    act_lo = 0;
  endtask

  task automatic wait_bits(input int n);
    repeat (n * cpb) @(posedge clk);
    #1;
  endtask

  // Drive one frame; caller is positioned #1 after a rising edge. Active is
  // sampled at each bit boundary inside the frame.
  task automatic send_frame(input logic [7:0] b, input logic stop, output int start);
    line  = 1'b0;
    start = cyc;
    wait_bits(1);
    for (int i = 0; i < 8; i++) begin
      if (!mon_act) act_lo++;
      line = b[i];
      wait_bits(1);
    end
    if (!mon_act) act_lo++;
    line = stop;
    wait_bits(1);
  endtask

  task automatic check_reset_outs(input string tag);
    check_val({tag, "_byte"}, int'(mon_byte), 0);
    check_val({tag, "_done"}, int'(mon_done), 0);
    check_val({tag, "_active"}, int'(mon_act), 0);
    check_val({tag, "_err"}, int'(mon_err), 0);
  endtask

  // Single frame and back-to-back frames; lat is cycles from line-low drive to done.
  task automatic run_basic(input int lat);
    int st, s0, s1, r0;
    clear_mon();
    r0 = act_rise;
    send_frame(8'hA5, 1'b1, st);
    wait_bits(2);
    check_val("a5_done_count", done_cyc_q.size(), 1);
    check_val("a5_latency", q_at(0) - st, lat);
    check_val("a5_byte", b_at(0), 'hA5);
    check_val("a5_byte_hold", int'(mon_byte), 'hA5);
    check_val("a5_active_gaps", act_lo, 0);
    check_val("a5_active_rises", act_rise - r0, 1);
    check_val("a5_active_after", int'(mon_act), 0);

    clear_mon();
    send_frame(8'h00, 1'b1, s0);
    send_frame(8'hFF, 1'b1, s1);
    wait_bits(2);
    check_val("b2b_done_count", done_cyc_q.size(), 2);
    check_val("b2b_latency0", q_at(0) - s0, lat);
    check_val("b2b_spacing", q_at(1) - q_at(0), 10 * cpb);
    check_val("b2b_byte0", b_at(0), 'h00);
    check_val("b2b_byte1", b_at(1), 'hFF);
    check_val("b2b_active_gaps", act_lo, 0);
  endtask

  initial begin
    int st, r0, e0;
    logic [7:0] pat;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outs("rst16");
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // 3 sync/detect edges + 1 + HALF(7) + 9*16
    run_basic(155);

    // Short low glitch on an idle line
    clear_mon();
    e0 = err_cnt;
    r0 = act_rise;
    line = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    line = 1'b1;
    wait_bits(3);
    check_val("glitch_active_pulse", act_rise - r0, 1);
    check_val("glitch_no_done", done_cyc_q.size(), 0);
    check_val("glitch_no_err", err_cnt - e0, 0);
    check_val("glitch_byte_kept", int'(mon_byte), 'hFF);
    send_frame(8'h3C, 1'b1, st);
    wait_bits(2);
    check_val("after_glitch_done", done_cyc_q.size(), 1);
    check_val("after_glitch_byte", int'(mon_byte), 'h3C);

    // Stop bit low followed by a long break
    clear_mon();
    e0 = err_cnt;
    r0 = act_rise;
    send_frame(8'h5A, 1'b0, st);
    wait_bits(40);
    check_val("ferr_pulses", err_cnt - e0, 1);
    check_val("ferr_no_done", done_cyc_q.size(), 0);
    check_val("ferr_byte_kept", int'(mon_byte), 'h3C);
    check_val("ferr_single_activity", act_rise - r0, 1);
    check_val("ferr_active_low", int'(mon_act), 0);
    line = 1'b1;
    wait_bits(2);
    send_frame(8'h81, 1'b1, st);
    wait_bits(2);
    check_val("after_break_done", done_cyc_q.size(), 1);
    check_val("after_break_byte", int'(mon_byte), 'h81);

    // Reset in the middle of data bit 4 of 0xF0
    clear_mon();
    e0 = err_cnt;
    pat = 8'hF0;
    line = 1'b0;
    wait_bits(1);
    for (int i = 0; i < 4; i++) begin
      line = pat[i];
      wait_bits(1);
    end
    line = pat[4];
    repeat (cpb / 2) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_reset_outs("midrst");
    line = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("midrst_no_done", done_cyc_q.size(), 0);
    check_val("midrst_no_err", err_cnt - e0, 0);
    wait_bits(2);
    send_frame(8'h0F, 1'b1, st);
    wait_bits(2);
    check_val("after_rst_done", done_cyc_q.size(), 1);
    check_val("after_rst_byte", int'(mon_byte), 'h0F);

    // Same basic cases on the 4-clock instance: HALF=1, latency 3+1+1+36
    reset = 1'b1;
    sel = 1'b1;
    cpb = 4;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outs("rst4");
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    run_basic(41);

    check_val("done_err_overlap", overlap, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
